input_channel_buffer: RTL

INPUT_CHANNEL_BUFFER -- requirements
Module: input_channel_buffer

---
 rtl/input_channel_buffer.sv | 101 ++++++++++
 1 files changed

// File: rtl/input_channel_buffer.sv
// Tagged input-channel FIFO: circular buffer with first-word fall-through head,
// back-pressure, synchronous flush and sticky overflow/underflow error flags.
module input_channel_buffer #(
  parameter int TIA_WORD_WIDTH = 32,
  parameter int TIA_TAG_WIDTH  = 2,
  parameter int BUFFER_DEPTH   = 4
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              push,
  input  logic [TIA_TAG_WIDTH-1:0]          push_tag,
  input  logic [TIA_WORD_WIDTH-1:0]         push_data,
  output logic                              full,
  input  logic                              dequeue,
  output logic                              empty,
  output logic [TIA_TAG_WIDTH-1:0]          head_tag,
  output logic [TIA_WORD_WIDTH-1:0]         head_data,
  output logic [$clog2(BUFFER_DEPTH):0]     occupancy,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUFFER_DEPTH);

  logic [TIA_TAG_WIDTH-1:0]  tag_mem_q  [BUFFER_DEPTH];
  logic [TIA_WORD_WIDTH-1:0] data_mem_q [BUFFER_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic empty_c, full_c, deq_ok, push_ok, wr_en;

  always_comb begin
    empty_c     = (occ_q == '0);
    full_c      = (occ_q == DEPTH_OCC);
    deq_ok      = dequeue && !empty_c;
    // A dequeue against an empty buffer freezes the whole cycle, including any push.
    push_ok     = push && !(dequeue && empty_c) && (!full_c || deq_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      wr_en = push_ok;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, deq_ok})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
      if (push && full_c && !dequeue) overflow_d  = 1'b1;
      if (dequeue && empty_c)         underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; validity is tracked entirely by the pointers and occupancy.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem_q[wr_ptr_q]  <= push_tag;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign empty     = empty_c;
  assign full      = full_c;
  assign occupancy = occ_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign head_tag  = tag_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

endmodule
